// File: rtl/result_sel_stage.sv
// Execute-stage result selector: picks a datapath slot or HI/LO, registers it
// for the MEM/WB boundary behind a valid/ready handshake, and owns HI/LO.
module result_sel_stage #(
   parameter int DATA_W  = 32,
   parameter int NUM_SRC = 4,
   parameter int SEL_W   = 2,
   parameter int HI_CODE = 1,
   parameter int LO_CODE = 2,
   parameter int CNT_W   = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [NUM_SRC*DATA_W-1:0] src_bus,
   input  logic [SEL_W-1:0]          sel,
   input  logic                      hilo_we,
   input  logic [DATA_W-1:0]         hi_in,
   input  logic [DATA_W-1:0]         lo_in,
   input  logic                      div_busy,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         data_out,
   output logic                      sel_err,
   output logic [CNT_W-1:0]          stall_cnt
);

   localparam logic [SEL_W-1:0] HI_SEL = SEL_W'(HI_CODE);
   localparam logic [SEL_W-1:0] LO_SEL = SEL_W'(LO_CODE);

   logic [DATA_W-1:0] hi_q;
   logic [DATA_W-1:0] lo_q;
   logic [DATA_W-1:0] sel_value;
   logic              hilo_hazard;
   logic              capture;
   logic              sel_illegal;

   assign hilo_hazard = in_valid && (sel == HI_SEL || sel == LO_SEL) && div_busy;
   assign in_ready    = (!out_valid || out_ready) && !hilo_hazard;
   assign capture     = in_valid && in_ready;
   assign sel_illegal = 32'(sel) >= 32'(NUM_SRC);

   // A divider write landing in the capture cycle is forwarded so the read never sees stale HI/LO.
   always_comb begin
      sel_value = '0;
      if (sel == HI_SEL) begin
         sel_value = hilo_we ? hi_in : hi_q;
      end else if (sel == LO_SEL) begin
         sel_value = hilo_we ? lo_in : lo_q;
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (sel == SEL_W'(i)) begin
               sel_value = src_bus[i*DATA_W +: DATA_W];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (hilo_we) begin
         hi_q <= hi_in;
         lo_q <= lo_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         data_out  <= '0;
         sel_err   <= 1'b0;
      end else if (capture) begin
         out_valid <= 1'b1;
         data_out  <= sel_value;
         sel_err   <= sel_illegal;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Saturates instead of wrapping so a long divider stall never reads as a short one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (hilo_hazard && stall_cnt != {CNT_W{1'b1}}) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: doc/result_sel_stage.md
Name: result_sel_stage

Overview:
Registered, parametrised execute-stage result selector with valid/ready handshake. It picks one of NUM_SRC datapath results or the internal HI/LO registers and forwards the selection to the MEM/WB boundary. It owns the HI/LO registers, which the divider writes. It stalls mfhi/mflo-type reads while the divider is busy, and bypasses a same-cycle HI/LO write.

Parameters:
DATA_W, 32, datapath width in bits
NUM_SRC, 4, number of source slots packed on src_bus (>=3)
SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_SRC
HI_CODE, 1, select code that reads the internal HI register instead of slot 1
LO_CODE, 2, select code that reads the internal LO register instead of slot 2
CNT_W, 16, width of the stall counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  upstream has a result to select
in_ready  out  1  stage accepts this cycle
src_bus  in  NUM_SRC*DATA_W  slot i at [i*DATA_W +: DATA_W]; slot 0 = ALU, slot 3 = shifter by convention
sel  in  SEL_W  source select, sampled with in_valid
hilo_we  in  1  divider done pulse; writes HI/LO
hi_in  in  DATA_W  divider remainder
lo_in  in  DATA_W  divider quotient
div_busy  in  1  divider operation in flight
out_valid  out  1  data_out holds a valid result
out_ready  in  1  downstream accepts
data_out  out  DATA_W  registered selected result
sel_err  out  1  registered with data_out; 1 when the captured sel >= NUM_SRC
stall_cnt  out  CNT_W  saturating count of HI/LO-hazard stall cycles

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, data_out=0, sel_err=0, HI=0, LO=0, stall_cnt=0. Any held result is dropped. The first capture happens on the first rising edge after rst_n rises.
- hilo_hazard = in_valid && (sel==HI_CODE || sel==LO_CODE) && div_busy.
- in_ready = (!out_valid || out_ready) && !hilo_hazard. This is combinational; it has no dependency on in_valid other than through hilo_hazard.
- Capture on in_valid && in_ready:
  - data_out is loaded with the selected value.
  - out_valid <= 1.
  - sel_err <= (sel >= NUM_SRC).
  - Latency is exactly 1 cycle.
- Selection:
  - sel==HI_CODE: HI value.
  - sel==LO_CODE: LO value.
  - Other sel < NUM_SRC: src_bus slot sel.
  - sel >= NUM_SRC: 0.
- Bypass: when hilo_we=1 in the capture cycle, an HI/LO select takes hi_in/lo_in, not the stale register.
- HI/LO update: on hilo_we, HI<=hi_in and LO<=lo_in. This is independent of the handshake and occurs even while stalled or when out_valid is held.
- Output hold: out_valid && !out_ready with no capture means data_out and sel_err stay stable.
- Output drain: out_ready && out_valid && no capture in the same cycle means out_valid <= 0. data_out keeps its last value.
- Simultaneous drain and capture: out_valid stays 1 and data_out updates. Full throughput is one result per cycle.
- stall_cnt increments on every cycle with hilo_hazard=1 and saturates at 2**CNT_W-1. It does not wrap.
- div_busy and hilo_we both 1: hazard still applies (busy dominates). HI/LO are still written.
- Non-HI/LO selects are never stalled by div_busy.
- Strictly synchronous apart from the reset. No combinational path from src_bus to data_out.

Test Plan:
- Reset/basic: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, data_out=0 immediately. Release, then present slot0=32'h0000_0005, sel=0 -> next cycle data_out=5, out_valid=1.
- Back-to-back: out_ready=1, sel sequence 0,3,0 with slot0=7, slot3=32'h80 -> data_out 7,32'h80,7 on consecutive cycles. in_ready stays 1 throughout.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0 and data_out is held for 5 cycles. Raise out_ready -> the pending input is captured the same edge.
- HI/LO hazard: div_busy=1 for 4 cycles, sel=LO_CODE -> in_ready=0 and stall_cnt=4. Then hilo_we=1, lo_in=32'h1234 with div_busy=0 -> captured data_out=32'h1234 (bypass). LO reads 32'h1234 afterwards.
- Illegal select: NUM_SRC=5, SEL_W=3, sel=7 -> data_out=0, sel_err=1 for that result only.
- Saturation: CNT_W=4, hold the hazard for 20 cycles -> stall_cnt=15 and remains 15.
